// File: rtl/mouse_init_sequencer.sv
// PS/2 mouse bring-up and packet sequencer.
// Resets the mouse (FF), checks the FA/AA/00 replies, enables streaming (F4),
// then assembles three-byte movement packets and publishes each complete one.
module mouse_init_sequencer #(
  parameter int POWERUP_CYCLES = 5000000,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic       INIT_DONE,
  output logic [3:0] STATE_CODE
);

  typedef enum logic [3:0] {
    S_INIT           = 4'd0,
    S_TX_RESET       = 4'd1,
    S_WAIT_TX_RESET  = 4'd2,
    S_WAIT_ACK1      = 4'd3,
    S_WAIT_SELFTEST  = 4'd4,
    S_WAIT_ID        = 4'd5,
    S_TX_ENABLE      = 4'd6,
    S_WAIT_TX_ENABLE = 4'd7,
    S_WAIT_ACK2      = 4'd8,
    S_RX_STATUS      = 4'd9,
    S_RX_DX          = 4'd10,
    S_RX_DY          = 4'd11,
    S_IRQ            = 4'd12
  } state_t;

  localparam logic [31:0] PWR_LAST = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  dx_q, dx_d;
  logic [7:0]  dy_q, dy_d;
  logic        send_q, read_en_q, irq_q, init_done_q;
  logic [7:0]  tx_byte_q;
  logic [7:0]  mouse_status_q, mouse_dx_q, mouse_dy_q;

  logic byte_ok, byte_err, timeout, powerup_done;

  assign byte_ok      = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
  assign byte_err     = BYTE_READY && (BYTE_ERROR_CODE != 2'b00);
  assign timeout      = (cnt_q == TMO_LAST);
  assign powerup_done = (cnt_q == PWR_LAST);

  // Next-state and partial-packet capture; byte-watching states only look at
  // the receiver while their registered READ_ENABLE is high.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    case (state_q)
      S_INIT:          if (powerup_done) state_d = S_TX_RESET;
      S_TX_RESET:      state_d = S_WAIT_TX_RESET;
      S_WAIT_TX_RESET: begin
        if (timeout)        state_d = S_INIT;
        else if (BYTE_SENT) state_d = S_WAIT_ACK1;
      end
      S_WAIT_ACK1: begin
        if (timeout || byte_err) state_d = S_INIT;
        else if (byte_ok) state_d = (BYTE_READ == 8'hFA) ? S_WAIT_SELFTEST : S_INIT;
      end
      S_WAIT_SELFTEST: begin
        if (timeout || byte_err) state_d = S_INIT;
        else if (byte_ok) state_d = (BYTE_READ == 8'hAA) ? S_WAIT_ID : S_INIT;
      end
      S_WAIT_ID: begin
        if (timeout || byte_err) state_d = S_INIT;
        else if (byte_ok) state_d = (BYTE_READ == 8'h00) ? S_TX_ENABLE : S_INIT;
      end
      S_TX_ENABLE:     state_d = S_WAIT_TX_ENABLE;
      S_WAIT_TX_ENABLE: begin
        if (timeout)        state_d = S_INIT;
        else if (BYTE_SENT) state_d = S_WAIT_ACK2;
      end
      S_WAIT_ACK2: begin
        if (timeout || byte_err) state_d = S_INIT;
        else if (byte_ok) state_d = (BYTE_READ == 8'hFA) ? S_RX_STATUS : S_INIT;
      end
      // Bit 3 is always set in a PS/2 status byte; anything else is a
      // misaligned stream and is dropped until a plausible header arrives.
      S_RX_STATUS: begin
        if (byte_ok && BYTE_READ[3]) begin
          status_d = BYTE_READ;
          state_d  = S_RX_DX;
        end
      end
      S_RX_DX: begin
        if (byte_ok) begin
          dx_d    = BYTE_READ;
          state_d = S_RX_DY;
        end else if (byte_err || timeout) begin
          state_d = S_RX_STATUS;
        end
      end
      S_RX_DY: begin
        if (byte_ok) begin
          dy_d    = BYTE_READ;
          state_d = S_IRQ;
        end else if (byte_err || timeout) begin
          state_d = S_RX_STATUS;
        end
      end
      S_IRQ:   state_d = S_RX_STATUS;
      default: state_d = S_INIT;
    endcase
  end

  // One shared counter: restarts on every state change.
  assign cnt_d = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;

  // State, counter and registered outputs; outputs are decoded from the next
  // state so they line up with the state they belong to.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q        <= S_INIT;
      cnt_q          <= 32'd0;
      status_q       <= 8'h00;
      dx_q           <= 8'h00;
      dy_q           <= 8'h00;
      send_q         <= 1'b0;
      tx_byte_q      <= 8'h00;
      read_en_q      <= 1'b0;
      irq_q          <= 1'b0;
      init_done_q    <= 1'b0;
      mouse_status_q <= 8'h00;
      mouse_dx_q     <= 8'h00;
      mouse_dy_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      // TX states last exactly one cycle, so the request is a single pulse.
      send_q   <= (state_d == S_TX_RESET) || (state_d == S_TX_ENABLE);
      if (state_d == S_TX_RESET)       tx_byte_q <= 8'hFF;
      else if (state_d == S_TX_ENABLE) tx_byte_q <= 8'hF4;
      read_en_q   <= !((state_d == S_INIT) || (state_d == S_TX_RESET) ||
                       (state_d == S_WAIT_TX_RESET) || (state_d == S_TX_ENABLE) ||
                       (state_d == S_WAIT_TX_ENABLE));
      init_done_q <= (state_d >= S_RX_STATUS);
      irq_q       <= (state_d == S_IRQ);
      // Publish the whole packet at once, together with the interrupt.
      if (state_d == S_IRQ) begin
        mouse_status_q <= status_d;
        mouse_dx_q     <= dx_d;
        mouse_dy_q     <= dy_d;
      end
    end
  end

  assign SEND_BYTE      = send_q;
  assign BYTE_TO_SEND   = tx_byte_q;
  assign READ_ENABLE    = read_en_q;
  assign MOUSE_STATUS   = mouse_status_q;
  assign MOUSE_DX       = mouse_dx_q;
  assign MOUSE_DY       = mouse_dy_q;
  assign SEND_INTERRUPT = irq_q;
  assign INIT_DONE      = init_done_q;
  assign STATE_CODE     = state_q;

endmodule

// File: doc/mouse_init_sequencer.md
MOUSE_INIT_SEQUENCER -- requirements
Module: mouse_init_sequencer

Interface
REQ-001 The block SHALL have parameter POWERUP_CYCLES, default 5000000, meaning idle cycles after reset before the first command (100 ms at 50 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 50000000, meaning the maximum number of cycles spent in any wait state before recovery.
REQ-003 The block SHALL have port CLK  in  1  system clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port RESET  in  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 The block SHALL have port SEND_BYTE  out  1  one-cycle request to the transmitter.
REQ-006 The block SHALL have port BYTE_TO_SEND  out  8  command byte; valid while SEND_BYTE=1.
REQ-007 The block SHALL have port BYTE_SENT  in  1  one-cycle transmitter completion pulse.
REQ-008 The block SHALL have port READ_ENABLE  out  1  receiver enable.
REQ-009 The block SHALL have port BYTE_READ  in  8  received byte.
REQ-010 The block SHALL have port BYTE_ERROR_CODE  in  2  receiver error flags; 00 means no error.
REQ-011 The block SHALL have port BYTE_READY  in  1  one-cycle received-byte strobe.
REQ-012 The block SHALL have ports MOUSE_STATUS, MOUSE_DX, MOUSE_DY  out  8 each  last complete packet.
REQ-013 The block SHALL have port SEND_INTERRUPT  out  1  one-cycle new-packet pulse.
REQ-014 The block SHALL have port INIT_DONE  out  1  high while streaming.
REQ-015 The block SHALL have port STATE_CODE  out  4  present state encoding, for debug.

Function
REQ-016 The state machine SHALL have the states INIT, TX_RESET, WAIT_TX_RESET, WAIT_ACK1, WAIT_SELFTEST, WAIT_ID, TX_ENABLE, WAIT_TX_ENABLE, WAIT_ACK2, RX_STATUS, RX_DX, RX_DY and IRQ, encoded 0 through 12 in that order.
REQ-017 A valid byte SHALL be defined as BYTE_READY=1 and BYTE_ERROR_CODE=00; a byte with BYTE_READY=1 and a nonzero error code is an error byte.
REQ-018 INIT SHALL count POWERUP_CYCLES cycles and then move to TX_RESET.
REQ-019 TX_RESET SHALL drive SEND_BYTE=1 and BYTE_TO_SEND=8'hFF for exactly one cycle, then move to WAIT_TX_RESET.
REQ-020 WAIT_TX_RESET SHALL move to WAIT_ACK1 on BYTE_SENT.
REQ-021 WAIT_ACK1, WAIT_SELFTEST and WAIT_ID SHALL advance on a valid byte equal to FA, AA and 00 respectively.
REQ-022 From WAIT_ID the machine SHALL advance to TX_ENABLE.
REQ-023 TX_ENABLE SHALL send 8'hF4 as a one-cycle SEND_BYTE pulse, then move to WAIT_TX_ENABLE.
REQ-024 WAIT_TX_ENABLE SHALL move to WAIT_ACK2 on BYTE_SENT.
REQ-025 WAIT_ACK2 SHALL move to RX_STATUS on a valid FA.
REQ-026 In any init wait state, a valid byte with the wrong value or an error byte SHALL return the machine to INIT, which restarts the POWERUP_CYCLES count.
REQ-027 A single cycle counter SHALL clear on every state change; in any state from WAIT_TX_RESET to WAIT_ACK2, reaching TIMEOUT_CYCLES-1 SHALL return the machine to INIT.
REQ-028 READ_ENABLE SHALL be 0 in INIT, TX_RESET, WAIT_TX_RESET, TX_ENABLE and WAIT_TX_ENABLE, and 1 in all other states.
REQ-029 BYTE_READY SHALL be ignored whenever READ_ENABLE=0.
REQ-030 RX_STATUS SHALL capture a valid byte with bit3=1 into an internal status register and move to RX_DX.
REQ-031 RX_STATUS SHALL discard a byte with bit3=0, and any error byte, and remain in RX_STATUS to resynchronise.
REQ-032 RX_DX and RX_DY SHALL capture valid bytes into internal dx/dy registers and advance.
REQ-033 An error byte, or a TIMEOUT_CYCLES expiry, in RX_DX or RX_DY SHALL discard the partial packet and return to RX_STATUS.
REQ-034 IRQ SHALL copy status/dx/dy to MOUSE_STATUS/MOUSE_DX/MOUSE_DY, assert SEND_INTERRUPT for exactly one cycle, and return to RX_STATUS.
REQ-035 The copy in IRQ SHALL update all three packet outputs in the same cycle, so packet outputs never show a partial packet.
REQ-036 INIT_DONE SHALL be 1 in RX_STATUS, RX_DX, RX_DY and IRQ, and 0 elsewhere.
REQ-037 SEND_BYTE SHALL never be asserted in two consecutive cycles.
REQ-038 BYTE_TO_SEND SHALL hold its last value when SEND_BYTE=0.
REQ-039 BYTE_SENT received in any state other than WAIT_TX_RESET or WAIT_TX_ENABLE SHALL be ignored.

Reset
REQ-040 While RESET=0, state SHALL be INIT, the counter 0, and all outputs 0, including BYTE_TO_SEND and the packet registers.
REQ-041 Assertion of RESET mid-transmit or mid-packet SHALL abort immediately with no further SEND_BYTE pulse.
REQ-042 Operation SHALL resume at INIT on the first rising CLK after RESET returns to 1.

Verification
REQ-043 The bench SHALL cover: POWERUP_CYCLES=10, bus-model mouse answers FA, AA, 00, then FA -> exactly two SEND_BYTE pulses (FF, then F4), and INIT_DONE=1 one cycle after the second FA.
REQ-044 The bench SHALL cover: streaming, bytes 08, 05, FB -> one SEND_INTERRUPT pulse, with MOUSE_STATUS=08, MOUSE_DX=05, MOUSE_DY=FB.
REQ-045 The bench SHALL cover: streaming, byte 00 then 09, 01, 02 -> 00 discarded, and one interrupt with status 09, dx 01, dy 02.
REQ-046 The bench SHALL cover: WAIT_SELFTEST receives FC -> the machine returns to INIT and the next SEND_BYTE carries FF.
REQ-047 The bench SHALL cover: TIMEOUT_CYCLES=100, no reply in WAIT_ACK1 -> INIT after 100 cycles, and the packet outputs are unchanged.
REQ-048 The bench SHALL cover: RESET=0 during RX_DY -> all outputs read 0 asynchronously, with no SEND_INTERRUPT.
